digit_scan_ctrl: RTL

Time-multiplexed digit scan sequencer feeding the 2-to-4 line decoder stage: it produces the decoder's 2-bit select and enable, plus the 4-bit nibble for the currently lit digit. It cycles through four digits with a programmable dwell time and an enable-off blanking gap between digits to prevent ghosting. It also supports per-digit masking and frame-coherent data capture. It sits between the display data source and the line decoder and seven-segment driver.

---
 rtl/scan_defs.sv | 28 ++
 rtl/scan_timer.sv | 39 +++
 rtl/digit_scan_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/scan_defs.sv
// Shared definitions for the digit scan sequencer: state encoding, digit
// geometry, the captured-frame payload and a nibble-select helper.
package scan_defs;

   localparam int unsigned NDIG   = 4;
   localparam int unsigned SEL_W  = 2;
   localparam int unsigned NIB_W  = 4;
   localparam int unsigned DATA_W = NDIG * NIB_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHOW  = 2'd1,
      ST_BLANK = 2'd2
   } state_e;

   // Frame snapshot taken at every frame start
   typedef struct packed {
      logic [NDIG-1:0]   mask;
      logic [DATA_W-1:0] data;
   } shadow_t;

   // Nibble of digit s out of a packed four-digit word
   function automatic logic [NIB_W-1:0] nib_of(input logic [DATA_W-1:0] d,
                                              input logic [SEL_W-1:0]  s);
      return d[{s, 2'b00} +: NIB_W];
   endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter used for both the dwell and the blanking interval.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   load     : load `value` into the counter this edge
//   value    : reload value (interval length minus one)
//   done     : counter has reached zero (decoded from the count register)
module scan_timer #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] value,
   output logic             done
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Load wins; otherwise count down and park at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = value;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/digit_scan_ctrl.sv
// Four-digit time-multiplexed scan sequencer for a 2-to-4 decoder display.
// Each digit is lit for DWELL cycles, followed by BLANK cycles with the
// decoder disabled so select changes never reach a lit digit.
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   run         : level-sensitive scan enable
//   data_in     : four nibbles, digit k in data_in[4k+3:4k]
//   mask        : per-digit lit enable
//   sel         : digit select to the decoder
//   en          : decoder enable
//   nibble      : data nibble of the selected digit
//   frame_start : one-cycle pulse on each frame capture
module digit_scan_ctrl
   import scan_defs::*;
#(
   parameter int unsigned CNT_W = 16,
   parameter int unsigned DWELL = 50000,
   parameter int unsigned BLANK = 500
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic [DATA_W-1:0] data_in,
   input  logic [NDIG-1:0]   mask,
   output logic [SEL_W-1:0]  sel,
   output logic              en,
   output logic [NIB_W-1:0]  nibble,
   output logic              frame_start
);

   // Timer counts reload-1 down to zero, giving exactly N cycles per interval
   localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);
   localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK - 1);
   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NDIG - 1);

   state_e           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             en_q, en_d;
   logic [NIB_W-1:0] nibble_q, nibble_d;
   logic             fs_q, fs_d;
   shadow_t          shadow_q, shadow_d;

   logic             tmr_load;
   logic [CNT_W-1:0] tmr_value;
   logic             tmr_done;

   scan_timer #(.CNT_W(CNT_W)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (tmr_load),
      .value (tmr_value),
      .done  (tmr_done)
   );

   // Next-state and registered-output decode
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      en_d      = 1'b0;
      nibble_d  = nibble_q;
      fs_d      = 1'b0;
      shadow_d  = shadow_q;
      tmr_load  = 1'b0;
      tmr_value = DWELL_LD;

      case (state_q)
         ST_IDLE: begin
            sel_d    = '0;
            nibble_d = '0;
            if (run) begin
               state_d       = ST_SHOW;
               shadow_d.mask = mask;
               shadow_d.data = data_in;
               fs_d          = 1'b1;
               tmr_load      = 1'b1;
               tmr_value     = DWELL_LD;
            end
         end
         ST_SHOW: begin
            // Dropping run aborts the dwell but still takes a full blank
            if (!run || tmr_done) begin
               state_d   = ST_BLANK;
               tmr_load  = 1'b1;
               tmr_value = BLANK_LD;
            end
         end
         ST_BLANK: begin
            if (tmr_done) begin
               if (!run) begin
                  state_d  = ST_IDLE;
                  sel_d    = '0;
                  nibble_d = '0;
               end else begin
                  state_d   = ST_SHOW;
                  tmr_load  = 1'b1;
                  tmr_value = DWELL_LD;
                  if (sel_q == LAST_SEL) begin
                     sel_d         = '0;
                     shadow_d.mask = mask;
                     shadow_d.data = data_in;
                     fs_d          = 1'b1;
                  end else begin
                     sel_d = sel_q + SEL_W'(1);
                  end
               end
            end
         end
         default: begin
            state_d  = ST_IDLE;
            sel_d    = '0;
            nibble_d = '0;
         end
      endcase

      // Lit digit follows the (possibly fresh) snapshot
      if (state_d == ST_SHOW) begin
         en_d     = shadow_d.mask[sel_d];
         nibble_d = nib_of(shadow_d.data, sel_d);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         sel_q    <= '0;
         en_q     <= 1'b0;
         nibble_q <= '0;
         fs_q     <= 1'b0;
         shadow_q <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         en_q     <= en_d;
         nibble_q <= nibble_d;
         fs_q     <= fs_d;
         shadow_q <= shadow_d;
      end
   end

   assign sel         = sel_q;
   assign en          = en_q;
   assign nibble      = nibble_q;
   assign frame_start = fs_q;

endmodule
